// File: rtl/game_phase_ctrl.sv
// Game-phase controller: Enter key synchroniser/debouncer plus START/PLACE/PLAY/OVER
// screen sequencing with active-player tracking for NUM_PLAYERS players.
module game_phase_ctrl #(
    parameter int unsigned NUM_PLAYERS     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    localparam int unsigned PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          Enter,
    input  logic          placement_done,
    input  logic          game_over,
    output logic          start,
    output logic [1:0]    screen,
    output logic [PW-1:0] player,
    output logic          enter_pulse
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] P_LAST  = PW'(NUM_PLAYERS - 1);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_PLACE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    state_t        state;
    logic          sync_1;
    logic          enter_sync;
    logic          enter_stable;
    logic          stable_q;
    logic [CW-1:0] db_cnt;

    // Two-flop synchroniser; resets high so a key held through reset is not a press
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1     <= 1'b1;
            enter_sync <= 1'b1;
        end else begin
            sync_1     <= Enter;
            enter_sync <= sync_1;
        end
    end

    // Debouncer: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enter_stable <= 1'b1;
            db_cnt       <= '0;
        end else if (enter_sync == enter_stable) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            enter_stable <= enter_sync;
            db_cnt       <= '0;
        end else begin
            db_cnt <= db_cnt + CW'(1);
        end
    end

    // One-cycle pulse on the accepted rising edge of Enter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_q    <= 1'b1;
            enter_pulse <= 1'b0;
        end else begin
            stable_q    <= enter_stable;
            enter_pulse <= enter_stable & ~stable_q;
        end
    end

    // Phase FSM with registered start flag and active-player index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_START;
            start  <= 1'b1;
            player <= '0;
        end else begin
            case (state)
                ST_START: begin
                    if (enter_pulse) begin
                        state  <= ST_PLACE;
                        start  <= 1'b0;
                        player <= '0;
                    end
                end
                ST_PLACE: begin
                    if (enter_pulse && placement_done) begin
                        if (player == P_LAST) begin
                            state  <= ST_PLAY;
                            player <= '0;
                        end else begin
                            player <= player + PW'(1);
                        end
                    end
                end
                ST_PLAY: begin
                    // game_over wins over a coincident press; player names the winner
                    if (game_over) begin
                        state <= ST_OVER;
                    end else if (enter_pulse) begin
                        player <= (player == P_LAST) ? '0 : player + PW'(1);
                    end
                end
                ST_OVER: begin
                    if (enter_pulse) begin
                        state  <= ST_START;
                        start  <= 1'b1;
                        player <= '0;
                    end
                end
            endcase
        end
    end

    assign screen = state;

endmodule

// File: tb/tb_game_phase_ctrl.sv
// Directed bench for game_phase_ctrl: a 3-player instance and a 1-player instance
// share all inputs; expected values are worked out by hand from the cycle timing.
module tb_game_phase_ctrl;

    logic       clk;
    logic       reset;
    logic       Enter;
    logic       placement_done;
    logic       game_over;
    logic       start;
    logic [1:0] screen;
    logic [1:0] player;
    logic       enter_pulse;
    logic       start1;
    logic [1:0] screen1;
    logic [0:0] player1;
    logic       enter_pulse1;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    game_phase_ctrl #(.NUM_PLAYERS(3), .DEBOUNCE_CYCLES(4)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .Enter          (Enter),
        .placement_done (placement_done),
        .game_over      (game_over),
        .start          (start),
        .screen         (screen),
        .player         (player),
        .enter_pulse    (enter_pulse)
    );

    game_phase_ctrl #(.NUM_PLAYERS(1), .DEBOUNCE_CYCLES(4)) u_dut1 (
        .clk            (clk),
        .reset          (reset),
        .Enter          (Enter),
        .placement_done (placement_done),
        .game_over      (game_over),
        .start          (start1),
        .screen         (screen1),
        .player         (player1),
        .enter_pulse    (enter_pulse1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counter sampled on the falling edge
    always @(negedge clk) if (enter_pulse) pulse_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hold Enter long enough to be accepted, then release long enough to re-arm
    task automatic press();
        Enter = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        Enter = 1'b0;
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int first_idx;
        int cnt;
        logic pat [5];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1; pat[4] = 1'b0;

        reset = 1'b0;
        Enter = 1'b0;
        placement_done = 1'b0;
        game_over = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_screen", 32'(screen), 32'd0);
        check("rst_start", 32'(start), 32'd1);
        check("rst_player", 32'(player), 32'd0);
        check("rst_pulse", 32'(enter_pulse), 32'd0);
        reset = 1'b1;

        // Idle with Enter low: the reset-high stable level falls silently
        repeat (50) @(posedge clk);
        #1;
        check("idle_pulses", 32'(pulse_cnt), 32'd0);
        check("idle_screen", 32'(screen), 32'd0);
        check("idle_start", 32'(start), 32'd1);

        // Clean press with exact latency: pulse after E7, screen after E8
        Enter = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (i == 6) check("clean_no_pulse_e6", 32'(enter_pulse), 32'd0);
            if (i == 7) begin
                check("clean_pulse_e7", 32'(enter_pulse), 32'd1);
                check("clean_screen_e7", 32'(screen), 32'd0);
            end
            if (i == 8) begin
                check("clean_pulse_e8", 32'(enter_pulse), 32'd0);
                check("clean_screen_e8", 32'(screen), 32'd1);
                check("clean_start_e8", 32'(start), 32'd0);
            end
        end
        repeat (12) @(posedge clk);
        #1;
        check("clean_one_pulse", 32'(pulse_cnt), 32'd1);
        Enter = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // Bounce 1,0,1,1,0 then held high from E6: pulse only after E12
        first_idx = 0;
        cnt = 0;
        for (int k = 1; k <= 16; k++) begin
            Enter = (k <= 5) ? pat[k-1] : 1'b1;
            @(posedge clk);
            #1;
            if (enter_pulse) begin
                cnt++;
                if (first_idx == 0) first_idx = k;
            end
        end
        check("bounce_pulse_edge", 32'(first_idx), 32'd12);
        check("bounce_pulse_count", 32'(cnt), 32'd1);
        Enter = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        // That press had placement_done low: nothing moves
        check("place_nodone_screen", 32'(screen), 32'd1);
        check("place_nodone_player", 32'(player), 32'd0);
        check("np1_nodone_screen", 32'(screen1), 32'd1);

        // Placement for three players
        placement_done = 1'b1;
        press();
        check("place_p1", 32'(player), 32'd1);
        check("place_p1_screen", 32'(screen), 32'd1);
        check("np1_play_screen", 32'(screen1), 32'd2);
        check("np1_play_player", 32'(player1), 32'd0);
        press();
        check("place_p2", 32'(player), 32'd2);
        press();
        check("play_screen", 32'(screen), 32'd2);
        check("play_player0", 32'(player), 32'd0);
        placement_done = 1'b0;

        // Turn rotation with wrap
        press();
        check("turn_1", 32'(player), 32'd1);
        press();
        check("turn_2", 32'(player), 32'd2);
        press();
        check("turn_wrap_0", 32'(player), 32'd0);
        check("np1_turn_player", 32'(player1), 32'd0);
        press();
        check("turn_1b", 32'(player), 32'd1);

        // game_over coincident with enter_pulse: OVER wins, player kept
        Enter = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (i == 7) begin
                check("go_pulse_e7", 32'(enter_pulse), 32'd1);
                game_over = 1'b1;
            end
            if (i == 8) game_over = 1'b0;
        end
        check("over_screen", 32'(screen), 32'd3);
        check("over_player", 32'(player), 32'd1);
        check("np1_over_screen", 32'(screen1), 32'd3);
        repeat (2) @(posedge clk);
        Enter = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        press();
        check("restart_screen", 32'(screen), 32'd0);
        check("restart_start", 32'(start), 32'd1);
        check("restart_player", 32'(player), 32'd0);

        // game_over outside PLAY is ignored
        game_over = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        game_over = 1'b0;
        check("go_in_start", 32'(screen), 32'd0);

        // Enter held through reset release gives no pulse
        reset = 1'b0;
        Enter = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        base = pulse_cnt;
        repeat (20) @(posedge clk);
        #1;
        check("held_rst_pulses", 32'(pulse_cnt - base), 32'd0);
        check("held_rst_screen", 32'(screen), 32'd0);
        Enter = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        press();
        check("repress_screen", 32'(screen), 32'd1);

        // Reach PLAY, then assert reset between edges: immediate abort
        placement_done = 1'b1;
        press();
        press();
        press();
        check("play2_screen", 32'(screen), 32'd2);
        press();
        check("play2_player", 32'(player), 32'd1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async_rst_screen", 32'(screen), 32'd0);
        check("async_rst_player", 32'(player), 32'd0);
        check("async_rst_start", 32'(start), 32'd1);
        repeat (2) @(posedge clk);
        reset = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_phase_ctrl.md
# game_phase_ctrl

Clocked game-phase controller: the parametrised successor to the single-flag start-screen latch. It synchronises and debounces the raw Enter key and sequences the display through START, ship PLACE, PLAY and game OVER screens. It also tracks the active player for NUM_PLAYERS players. It sits between the keyboard front end and the VGA/game logic, which key off `screen`, `player` and `start`.

## Interface
- NUM_PLAYERS, 2, number of players (≥1); placement and turns rotate through 0..NUM_PLAYERS-1
- DEBOUNCE_CYCLES, 16, consecutive stable cycles (≥1) required to accept a new Enter level
- PW (localparam), max(1, clog2(NUM_PLAYERS)), width of `player`

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- Enter  in  1  raw Enter key level, asynchronous to clk, bouncy
- placement_done  in  1  level from game logic: active player has placed all ships
- game_over  in  1  level from game logic: win condition reached
- start  out  1  high while on START screen (legacy compatibility)
- screen  out  2  0=START, 1=PLACE, 2=PLAY, 3=OVER
- player  out  PW  active player index
- enter_pulse  out  1  one-cycle pulse per accepted Enter press

## Operation
- Synchroniser: 2-flop chain on Enter → `enter_sync`.
- Debouncer: accepted level `enter_stable`, counter `db_cnt` of width clog2(DEBOUNCE_CYCLES+1).
  - enter_sync == enter_stable → db_cnt ← 0.
  - Otherwise, if db_cnt == DEBOUNCE_CYCLES-1 → enter_stable ← enter_sync, db_cnt ← 0; else db_cnt ← db_cnt+1.
  - Any bounce back to the stable level restarts the count.
- enter_pulse: registered, high for exactly one cycle after enter_stable goes 0→1. Falling edges produce nothing.
- FSM transitions are evaluated in the cycle enter_pulse is high; the new state appears after the next edge.
  - START: enter_pulse → PLACE, player ← 0.
  - PLACE: enter_pulse && placement_done:
    - player == NUM_PLAYERS-1 → PLAY, player ← 0.
    - else player ← player+1.
    - enter_pulse without placement_done is ignored.
  - PLAY:
    - game_over → OVER; player holds and identifies the winner. game_over has priority over a same-cycle enter_pulse.
    - else enter_pulse → player ← (player+1) mod NUM_PLAYERS, wrapping to 0.
  - OVER: enter_pulse → START, player ← 0.
- game_over outside PLAY is ignored.
- start = (screen == START). It is registered with the state, never combinational glitching.
- NUM_PLAYERS=1: player is constantly 0; PLACE→PLAY happens on the first valid confirm.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - screen=0, start=1, player=0, enter_pulse=0.
  - Sync flops ← 1, enter_stable ← 1, db_cnt ← 0.
- Reset values of the Enter path are 1 by design. A key held through reset release produces no pulse; it must be released (debounced low) and pressed again.
- Press latency: with Enter high and stable from the first sampling edge E1, enter_stable rises after edge E(2+DEBOUNCE_CYCLES), enter_pulse is high after edge E(3+DEBOUNCE_CYCLES), and screen/player update after edge E(4+DEBOUNCE_CYCLES).
- Release must likewise be stable DEBOUNCE_CYCLES cycles before a new press is recognised. The minimum press-to-press period is 2·DEBOUNCE_CYCLES cycles plus sync delay.
- Reset asserted mid-debounce or mid-game aborts immediately to START; there is no partial state.
- A single held press yields exactly one enter_pulse, regardless of duration.

## Test plan
- Reset/idle, DEBOUNCE_CYCLES=4, Enter=0 during and after reset → start=1, screen=0, player=0; no enter_pulse in 50 cycles.
- Clean press, DEBOUNCE_CYCLES=4: Enter high from E1, held 20 cycles → exactly one enter_pulse, after edge E7; screen=1 after E8; start=0.
- Bounce: Enter toggles 1,0,1,1,0 then held high → pulse only after 4 consecutive high synced cycles; no extra pulse from the glitches.
- Full game, NUM_PLAYERS=3:
  - Press in PLACE with placement_done=0 → no change.
  - With placement_done=1, three presses → player 0→1→2, then screen=2, player=0.
  - Four presses in PLAY → player 1,2,0,1 (wrap).
- Simultaneous game_over and enter_pulse in PLAY with player=1 → screen=3, player=1. A further press → screen=0, start=1, player=0.
- Enter held high across reset release → no pulse. Release then re-press → screen=1. Reset asserted mid-PLAY → immediate screen=0, player=0.
